fnd_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit common-anode seven-segment display (FND) of the min/sec timer. It takes the four BCD digits from the digit-splitting stage and double-buffers them so a frame never tears. It then scans one digit per refresh tick onto the shared segment bus, adding per-digit blink, decimal point and leading-zero blanking. It sits between the digit splitter and the board FND pins.

---
 rtl/fnd_pkg.sv | 39 +++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/fnd_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the seven-segment display scan controller.
package fnd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;

    // Active-low segment codes, {dp,g,f,e,d,c,b,a}, dp off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] COM_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // One buffered frame: four BCD digits plus per-digit decimal points.
    typedef struct packed {
        logic [BCD_W-1:0]      d3;
        logic [BCD_W-1:0]      d2;
        logic [BCD_W-1:0]      d1;
        logic [BCD_W-1:0]      d0;
        logic [NUM_DIGITS-1:0] dp;
    } frame_t;

    // Active-low one-hot anode select for the given digit.
    function automatic logic [3:0] com_sel(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    // Segment lookup, dp excluded.
    always_comb begin
        seg_c = SEG_DASH[6:0];
        case (bcd)
            4'd0:    seg_c = SEG_0[6:0];
            4'd1:    seg_c = SEG_1[6:0];
            4'd2:    seg_c = SEG_2[6:0];
            4'd3:    seg_c = SEG_3[6:0];
            4'd4:    seg_c = SEG_4[6:0];
            4'd5:    seg_c = SEG_5[6:0];
            4'd6:    seg_c = SEG_6[6:0];
            4'd7:    seg_c = SEG_7[6:0];
            4'd8:    seg_c = SEG_8[6:0];
            4'd9:    seg_c = SEG_9[6:0];
            default: seg_c = SEG_DASH[6:0];
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit common-anode FND scanner with double-buffered frames, blink,
// decimal points and leading-zero blanking.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned BLINK_TICKS = 250
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_10,
    input  logic [3:0] digit_100,
    input  logic [3:0] digit_1000,
    input  logic       update,
    input  logic [3:0] dp_mask,
    input  logic [3:0] blink_en,
    input  logic       lz_blank,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data,
    output logic       frame_done
);

    localparam int unsigned DIV    = CLK_HZ / SCAN_HZ;
    localparam int unsigned TCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BCNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [TCNT_W-1:0] tcnt;
    logic [BCNT_W-1:0] bcnt;
    digit_idx_t        sel;
    logic              blink_ph;
    logic              pend;
    frame_t            pend_buf;
    frame_t            act_buf;

    logic              tick_c;
    logic              boundary_c;
    frame_t            in_frame_c;
    logic [3:0]        cur_digit_c;
    logic              cur_dp_c;
    logic              lz_hide_c;
    logic              blink_hide_c;
    logic [6:0]        seg_c;
    logic [7:0]        data_nxt_c;

    assign tick_c     = (tcnt == TCNT_W'(DIV - 1));
    assign boundary_c = tick_c && (sel == 2'd3);
    assign in_frame_c = '{d3: digit_1000, d2: digit_100, d1: digit_10, d0: digit_1, dp: dp_mask};

    // Tick divider, scan index, blink phase and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt       <= '0;
            sel        <= '0;
            bcnt       <= '0;
            blink_ph   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary_c;
            if (tick_c) begin
                tcnt <= '0;
                sel  <= sel + 2'd1;
                if (bcnt == BCNT_W'(BLINK_TICKS - 1)) begin
                    bcnt     <= '0;
                    blink_ph <= ~blink_ph;
                end else begin
                    bcnt <= bcnt + BCNT_W'(1);
                end
            end else begin
                tcnt <= tcnt + TCNT_W'(1);
            end
        end
    end

    // Pending/active double buffer; active only changes at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            pend_buf <= '0;
            act_buf  <= '0;
        end else if (boundary_c && update) begin
            act_buf <= in_frame_c;
            pend    <= 1'b0;
        end else if (boundary_c && pend) begin
            act_buf <= pend_buf;
            pend    <= 1'b0;
        end else if (update) begin
            pend_buf <= in_frame_c;
            pend     <= 1'b1;
        end
    end

    // Pick the digit under scan and work out blink / leading-zero suppression.
    always_comb begin
        cur_digit_c = act_buf.d0;
        lz_hide_c   = 1'b0;
        case (sel)
            2'd0: cur_digit_c = act_buf.d0;
            2'd1: begin
                cur_digit_c = act_buf.d1;
                lz_hide_c   = lz_blank && (act_buf.d3 == 4'd0) && (act_buf.d2 == 4'd0)
                              && (act_buf.d1 == 4'd0);
            end
            2'd2: begin
                cur_digit_c = act_buf.d2;
                lz_hide_c   = lz_blank && (act_buf.d3 == 4'd0) && (act_buf.d2 == 4'd0);
            end
            default: begin
                cur_digit_c = act_buf.d3;
                lz_hide_c   = lz_blank && (act_buf.d3 == 4'd0);
            end
        endcase
        cur_dp_c     = act_buf.dp[sel];
        blink_hide_c = blink_ph && blink_en[sel];
    end

    bcd_to_seg u_dec (
        .bcd   (cur_digit_c),
        .seg_c (seg_c)
    );

    // Final segment pattern; a leading-zero-blanked digit keeps its dp.
    always_comb begin
        data_nxt_c = SEG_BLANK;
        if (blink_hide_c) begin
            data_nxt_c = SEG_BLANK;
        end else if (lz_hide_c) begin
            data_nxt_c = {~cur_dp_c, 7'h7F};
        end else begin
            data_nxt_c = {~cur_dp_c, seg_c};
        end
    end

    // Registered pin drivers, forced off during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fnd_com  <= COM_OFF;
            fnd_data <= SEG_BLANK;
        end else begin
            fnd_com  <= com_sel(sel);
            fnd_data <= data_nxt_c;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with DIV = 4 and BLINK_TICKS = 2.
// Cycle t counts rising edges since reset release; outputs after edge t show
// digit ((t-1)/4)%4, and frame boundaries fall on edges 16, 32, 48, ...
module tb_fnd_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_1 = '0;
    logic [3:0] digit_10 = '0;
    logic [3:0] digit_100 = '0;
    logic [3:0] digit_1000 = '0;
    logic       update = 1'b0;
    logic [3:0] dp_mask = '0;
    logic [3:0] blink_en = '0;
    logic       lz_blank = 1'b0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    fnd_scan_ctrl #(
        .CLK_HZ      (40),
        .SCAN_HZ     (10),
        .BLINK_TICKS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_1    (digit_1),
        .digit_10   (digit_10),
        .digit_100  (digit_100),
        .digit_1000 (digit_1000),
        .update     (update),
        .dp_mask    (dp_mask),
        .blink_en   (blink_en),
        .lz_blank   (lz_blank),
        .fnd_com    (fnd_com),
        .fnd_data   (fnd_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after rising edge p.
    task automatic goto(input int p);
        repeat (p - t) @(posedge clk);
        t = p;
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] com, input logic [7:0] data);
        chk({tag, ".com"}, {4'h0, fnd_com}, {4'h0, com});
        chk({tag, ".data"}, fnd_data, data);
    endtask

    task automatic chk_fd(input string tag, input logic exp);
        chk(tag, {7'h0, frame_done}, {7'h0, exp});
    endtask

    task automatic set_in(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                          input logic [3:0] d3, input logic [3:0] dp);
        digit_1    = d0;
        digit_10   = d1;
        digit_100  = d2;
        digit_1000 = d3;
        dp_mask    = dp;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 4'b1111, 8'hFF);
        chk_fd("reset.fd", 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        t = 0;

        // Idle scan of all-zero active registers
        goto(1);  chk_out("idle.d0", 4'b1110, 8'hC0);
        goto(4);  chk_out("idle.d0.hold", 4'b1110, 8'hC0);
        goto(5);  chk_out("idle.d1", 4'b1101, 8'hC0);
        goto(9);  chk_out("idle.d2", 4'b1011, 8'hC0);
        goto(13); chk_out("idle.d3", 4'b0111, 8'hC0);
        goto(15); chk_fd("fd.15", 1'b0);
        goto(16); chk_fd("fd.16", 1'b1);
        goto(17); chk_fd("fd.17", 1'b0);
        chk_out("idle.wrap", 4'b1110, 8'hC0);
        goto(32); chk_fd("fd.32", 1'b1);

        // Mid-frame update: held until the boundary at edge 48
        goto(34);
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100);
        update = 1'b1;
        goto(35);
        update = 1'b0;
        set_in(4'd9, 4'd9, 4'd9, 4'd9, 4'b1111);
        goto(37); chk_out("mid.old.d1", 4'b1101, 8'hC0);
        goto(48); chk_out("mid.old.d3", 4'b0111, 8'hC0);
        goto(49); chk_out("mid.new.d0", 4'b1110, 8'hF9);
        goto(53); chk_out("mid.new.d1", 4'b1101, 8'hA4);
        goto(57); chk_out("mid.new.d2dp", 4'b1011, 8'h30);
        goto(61); chk_out("mid.new.d3", 4'b0111, 8'h99);

        // Update coinciding with the boundary at edge 64
        goto(63);
        set_in(4'd5, 4'd2, 4'd3, 4'd4, 4'b0100);
        update = 1'b1;
        goto(64);
        update = 1'b0;
        chk_fd("bnd.fd", 1'b1);
        goto(65); chk_out("bnd.d0", 4'b1110, 8'h92);

        // Two updates before the next boundary: the second must win
        goto(66);
        set_in(4'd8, 4'd8, 4'd8, 4'd8, 4'b1111);
        update = 1'b1;
        goto(67);
        update = 1'b0;
        goto(70);
        set_in(4'd0, 4'd7, 4'd0, 4'd0, 4'b0100);
        update = 1'b1;
        lz_blank = 1'b1;
        goto(71);
        update = 1'b0;
        goto(77); chk_out("lw.old.d3", 4'b0111, 8'h99);
        goto(81); chk_out("lz.d0", 4'b1110, 8'hC0);
        goto(85); chk_out("lz.d1", 4'b1101, 8'hF8);
        goto(89); chk_out("lz.d2keepdp", 4'b1011, 8'h7F);
        goto(93); chk_out("lz.d3", 4'b0111, 8'hFF);

        // Out-of-range BCD shows a dash and stops digit 2 from being blanked
        set_in(4'd0, 4'd7, 4'd0, 4'd12, 4'b0000);
        update = 1'b1;
        goto(94);
        update = 1'b0;
        goto(97);  chk_out("dash.d0", 4'b1110, 8'hC0);
        goto(101); chk_out("dash.d1", 4'b1101, 8'hF8);
        goto(105); chk_out("dash.d2", 4'b1011, 8'hC0);
        goto(109); chk_out("dash.d3", 4'b0111, 8'hBF);

        // Blink: phase toggles every 8 edges, so digits 0/1 fall in phase 0
        // and digits 2/3 in phase 1 at this ratio.
        goto(112);
        blink_en = 4'b0001;
        goto(113); chk_out("blink.d0.ph0", 4'b1110, 8'hC0);
        goto(117); chk_out("blink.d1.steady", 4'b1101, 8'hF8);
        goto(120);
        blink_en = 4'b0100;
        goto(121); chk_out("blink.d2.off", 4'b1011, 8'hFF);
        goto(122);
        blink_en = 4'b0000;
        goto(123); chk_out("blink.d2.live", 4'b1011, 8'hC0);
        goto(124);
        blink_en = 4'b1000;
        goto(125); chk_out("blink.d3.off", 4'b0111, 8'hFF);
        goto(128);
        blink_en = 4'b0000;

        // Asynchronous reset mid-frame discards pending and active data
        goto(140);
        set_in(4'd9, 4'd9, 4'd9, 4'd9, 4'b1111);
        update = 1'b1;
        goto(141);
        update = 1'b0;
        goto(142);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 4'b1111, 8'hFF);
        chk_fd("arst.fd", 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        goto(1);  chk_out("post.d0", 4'b1110, 8'hC0);
        goto(17); chk_out("post.frame2.d0", 4'b1110, 8'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
